// File: rtl/mem_line_requester_if.sv
// Bundle of I-cache, D-cache and memory-port signals for the line requester.
// Latency: none, wires only.
// Backpressure: requests are levels held until the matching one-cycle ready pulse.
interface mem_line_requester_if #(
    parameter int ADDR_W = 26,
    parameter int LINE_W = 128
);
    logic              ic_req;
    logic [ADDR_W-1:0] ic_addr;
    logic              ic_ready;
    logic [LINE_W-1:0] ic_rdata;

    logic              dc_req;
    logic              dc_we;
    logic [ADDR_W-1:0] dc_addr;
    logic [LINE_W-1:0] dc_wdata;
    logic              dc_ready;
    logic [LINE_W-1:0] dc_rdata;

    logic [ADDR_W-1:0] mem_rd_addr;
    logic [ADDR_W-1:0] mem_wr_addr;
    logic [LINE_W-1:0] mem_wdata;
    logic              mem_we;
    logic [LINE_W-1:0] mem_rdata;

    // Requester view: serves the caches, initiates memory accesses.
    modport master (
        input  ic_req, ic_addr,
        output ic_ready, ic_rdata,
        input  dc_req, dc_we, dc_addr, dc_wdata,
        output dc_ready, dc_rdata,
        output mem_rd_addr, mem_wr_addr, mem_wdata, mem_we,
        input  mem_rdata
    );

    // Environment view: caches and memory.
    modport slave (
        output ic_req, ic_addr,
        input  ic_ready, ic_rdata,
        output dc_req, dc_we, dc_addr, dc_wdata,
        input  dc_ready, dc_rdata,
        input  mem_rd_addr, mem_wr_addr, mem_wdata, mem_we,
        output mem_rdata
    );
endinterface

// File: rtl/mem_line_requester.sv
// Arbitrates I-cache/D-cache line requests onto a fixed-latency 128-bit memory port.
// Latency: request seen in IDLE -> ready pulse MEM_LATENCY+1 cycles later; one access in flight.
// Backpressure: requests are held levels, served one at a time; MEMREQ_ROUND_ROBIN_EN selects round-robin.
module mem_line_requester #(
    parameter int ADDR_W      = 26,
    parameter int LINE_W      = 128,
    parameter int MEM_LATENCY = 5
) (
    input  logic                 clk,
    input  logic                 reset,
    mem_line_requester_if.master bus,
    output logic                 busy
);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_ACCESS = 2'd1,
        S_DONE   = 2'd2
    } state_t;

    localparam logic [3:0] CNT_INIT = 4'(MEM_LATENCY - 1);

    state_t            state;
    state_t            state_nxt;
    logic [3:0]        cnt;
    logic [ADDR_W-1:0] lat_addr;
    logic [LINE_W-1:0] lat_wdata;
    logic              lat_we;
    logic              lat_dc;
    logic [LINE_W-1:0] ic_rdata_q;
    logic [LINE_W-1:0] dc_rdata_q;
    logic              any_req;
    logic              grant_dc;
    logic              in_access;
`ifdef MEMREQ_ROUND_ROBIN_EN
    logic              hist_dc;
`endif

    // Choose which requester wins when leaving IDLE.
    always_comb begin
        any_req = bus.ic_req | bus.dc_req;
`ifdef MEMREQ_ROUND_ROBIN_EN
        // On contention the requester not served last wins.
        grant_dc = bus.dc_req & (~bus.ic_req | ~hist_dc);
`else
        grant_dc = bus.dc_req;
`endif
    end

    // State register.
    always_ff @(posedge clk) begin
        if (reset) state <= S_IDLE;
        else       state <= state_nxt;
    end

    // Next-state logic: DONE always returns to IDLE, so grants are never back-to-back.
    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:   if (any_req) state_nxt = S_ACCESS;
            S_ACCESS: if (cnt == 4'd0) state_nxt = S_DONE;
            S_DONE:   state_nxt = S_IDLE;
            default:  state_nxt = S_IDLE;
        endcase
    end

    // Latch the granted request, run the latency counter, capture read data.
    always_ff @(posedge clk) begin
        if (reset) begin
            cnt        <= 4'd0;
            lat_addr   <= '0;
            lat_wdata  <= '0;
            lat_we     <= 1'b0;
            lat_dc     <= 1'b0;
            ic_rdata_q <= '0;
            dc_rdata_q <= '0;
`ifdef MEMREQ_ROUND_ROBIN_EN
            hist_dc    <= 1'b0;
`endif
        end else begin
            case (state)
                S_IDLE: begin
                    if (any_req) begin
                        lat_dc    <= grant_dc;
                        lat_addr  <= grant_dc ? bus.dc_addr : bus.ic_addr;
                        lat_we    <= grant_dc & bus.dc_we;
                        lat_wdata <= (grant_dc & bus.dc_we) ? bus.dc_wdata : '0;
                        cnt       <= CNT_INIT;
`ifdef MEMREQ_ROUND_ROBIN_EN
                        hist_dc   <= grant_dc;
`endif
                    end
                end
                S_ACCESS: begin
                    if (cnt == 4'd0) begin
                        // Writes leave the requester's rdata untouched.
                        if (!lat_we) begin
                            if (lat_dc) dc_rdata_q <= bus.mem_rdata;
                            else        ic_rdata_q <= bus.mem_rdata;
                        end
                    end else begin
                        cnt <= cnt - 4'd1;
                    end
                end
                default: ;
            endcase
        end
    end

    // Outputs decoded from state; memory port is zero outside ACCESS.
    always_comb begin
        in_access       = (state == S_ACCESS);
        busy            = (state != S_IDLE);
        bus.mem_rd_addr = in_access ? lat_addr : '0;
        bus.mem_wr_addr = in_access ? lat_addr : '0;
        bus.mem_wdata   = in_access ? lat_wdata : '0;
        bus.mem_we      = in_access && (cnt == 4'd0) && lat_we;
        bus.ic_ready    = (state == S_DONE) && !lat_dc;
        bus.dc_ready    = (state == S_DONE) && lat_dc;
        bus.ic_rdata    = ic_rdata_q;
        bus.dc_rdata    = dc_rdata_q;
    end

endmodule

// File: tb/tb_mem_line_requester.sv
// Directed bench for mem_line_requester: reads, writes, contention, reset abort, latency 1.
// Latency: checks ready-pulse cycle positions relative to the request cycle.
// Backpressure: requests held until ready, dropped in the DONE cycle.
module tb_mem_line_requester;

    localparam logic [127:0] LINE_10 = 128'h00000043_00000042_00000041_00000040;
    localparam logic [127:0] LINE_20 = 128'h00000083_00000082_00000081_00000080;
    localparam logic [127:0] LINE_30 = 128'h000000C3_000000C2_000000C1_000000C0;
    localparam logic [127:0] WDATA   = 128'hDEADBEEF_01234567_89ABCDEF_CAFEF00D;

    logic clk = 1'b0;
    logic reset;
    logic busy0;
    logic busy1;
    int   n_total = 0;
    int   n_bad   = 0;

    always #5 clk = ~clk;

    mem_line_requester_if #(.ADDR_W(26), .LINE_W(128)) bus0 ();
    mem_line_requester_if #(.ADDR_W(26), .LINE_W(128)) bus1 ();

    mem_line_requester #(.ADDR_W(26), .LINE_W(128), .MEM_LATENCY(5)) u_dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus0),
        .busy  (busy0)
    );

    mem_line_requester #(.ADDR_W(26), .LINE_W(128), .MEM_LATENCY(1)) u_dut_l1 (
        .clk   (clk),
        .reset (reset),
        .bus   (bus1),
        .busy  (busy1)
    );

    // Memory model: line at address A holds words 4A+3..4A.
    function automatic logic [127:0] line_of(input logic [25:0] a);
        logic [31:0] w;
        w = {4'b0000, a, 2'b00};
        return {w + 32'd3, w + 32'd2, w + 32'd1, w};
    endfunction

    assign bus0.mem_rdata = line_of(bus0.mem_rd_addr);
    assign bus1.mem_rdata = line_of(bus1.mem_rd_addr);

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        bus0.ic_req = 1'b0; bus0.ic_addr = '0;
        bus0.dc_req = 1'b0; bus0.dc_we = 1'b0; bus0.dc_addr = '0; bus0.dc_wdata = '0;
        bus1.ic_req = 1'b0; bus1.ic_addr = '0;
        bus1.dc_req = 1'b0; bus1.dc_we = 1'b0; bus1.dc_addr = '0; bus1.dc_wdata = '0;
    endtask

    initial begin
        int we_cnt;
        int ic_at;
        int dc_at;
        int we_seen;
        int rdy_seen;
        int exp_ic_at;
        int exp_dc_at;

        // Reset state
        reset = 1'b1;
        idle_inputs();
        step();
        step();
        check("rst_busy",     busy0,             1'b0);
        check("rst_ic_ready", bus0.ic_ready,     1'b0);
        check("rst_dc_ready", bus0.dc_ready,     1'b0);
        check("rst_mem_we",   bus0.mem_we,       1'b0);
        check("rst_rd_addr",  bus0.mem_rd_addr,  26'h0);
        check("rst_ic_rdata", bus0.ic_rdata,     128'h0);
        check("rst_busy_l1",  busy1,             1'b0);
        reset = 1'b0;

        // I-cache read of line 0x10
        bus0.ic_req  = 1'b1;
        bus0.ic_addr = 26'h10;
        for (int c = 1; c <= 6; c++) begin
            step();
            if (c <= 5) begin
                check("t1_rd_addr",  bus0.mem_rd_addr, 26'h10);
                check("t1_ready_lo", bus0.ic_ready,    1'b0);
                check("t1_we_lo",    bus0.mem_we,      1'b0);
                check("t1_busy",     busy0,            1'b1);
            end else begin
                check("t1_ready_hi",  bus0.ic_ready,    1'b1);
                check("t1_ic_rdata",  bus0.ic_rdata,    LINE_10);
                check("t1_done_addr", bus0.mem_rd_addr, 26'h0);
                check("t1_done_we",   bus0.mem_we,      1'b0);
                bus0.ic_req = 1'b0;
            end
        end
        step();
        check("t1_idle_busy",  busy0,         1'b0);
        check("t1_ready_gone", bus0.ic_ready, 1'b0);

        // D-cache write of line 0x400
        bus0.dc_req   = 1'b1;
        bus0.dc_we    = 1'b1;
        bus0.dc_addr  = 26'h400;
        bus0.dc_wdata = WDATA;
        we_cnt = 0;
        for (int c = 1; c <= 6; c++) begin
            step();
            if (bus0.mem_we) we_cnt++;
            if (c == 5) begin
                check("t2_we_hi",    bus0.mem_we,      1'b1);
                check("t2_wr_addr",  bus0.mem_wr_addr, 26'h400);
                check("t2_wdata",    bus0.mem_wdata,   WDATA);
                check("t2_ready_lo", bus0.dc_ready,    1'b0);
            end
            if (c == 6) begin
                check("t2_dc_ready", bus0.dc_ready, 1'b1);
                check("t2_dc_rdata", bus0.dc_rdata, 128'h0);
                check("t2_ic_ready", bus0.ic_ready, 1'b0);
                bus0.dc_req = 1'b0;
                bus0.dc_we  = 1'b0;
            end
        end
        step();
        check("t2_we_count", we_cnt,      1);
        check("t2_idle_we",  bus0.mem_we, 1'b0);

        // Simultaneous read requests, held until served
        bus0.ic_req  = 1'b1;
        bus0.ic_addr = 26'h20;
        bus0.dc_req  = 1'b1;
        bus0.dc_we   = 1'b0;
        bus0.dc_addr = 26'h30;
        ic_at = -1;
        dc_at = -1;
        for (int c = 1; c <= 20; c++) begin
            step();
            if (bus0.ic_ready && ic_at < 0) begin
                ic_at = c;
                bus0.ic_req = 1'b0;
            end
            if (bus0.dc_ready && dc_at < 0) begin
                dc_at = c;
                bus0.dc_req = 1'b0;
            end
        end
`ifdef MEMREQ_ROUND_ROBIN_EN
        exp_ic_at = 6;
        exp_dc_at = 13;
`else
        exp_dc_at = 6;
        exp_ic_at = 13;
`endif
        check("t3_ic_cycle", ic_at,         exp_ic_at);
        check("t3_dc_cycle", dc_at,         exp_dc_at);
        check("t3_ic_rdata", bus0.ic_rdata, LINE_20);
        check("t3_dc_rdata", bus0.dc_rdata, LINE_30);

        // Reset in the third ACCESS cycle of a write
        bus0.dc_req   = 1'b1;
        bus0.dc_we    = 1'b1;
        bus0.dc_addr  = 26'h500;
        bus0.dc_wdata = WDATA;
        step();
        step();
        step();
        check("t4_busy_acc", busy0,       1'b1);
        check("t4_we_acc",   bus0.mem_we, 1'b0);
        reset = 1'b1;
        step();
        reset = 1'b0;
        bus0.dc_req = 1'b0;
        bus0.dc_we  = 1'b0;
        check("t4_busy",     busy0,             1'b0);
        check("t4_we",       bus0.mem_we,       1'b0);
        check("t4_dc_ready", bus0.dc_ready,     1'b0);
        check("t4_wr_addr",  bus0.mem_wr_addr,  26'h0);
        check("t4_wdata",    bus0.mem_wdata,    128'h0);
        check("t4_dc_rdata", bus0.dc_rdata,     128'h0);
        check("t4_ic_rdata", bus0.ic_rdata,     128'h0);
        we_seen  = 0;
        rdy_seen = 0;
        for (int c = 0; c < 8; c++) begin
            step();
            if (bus0.mem_we)   we_seen++;
            if (bus0.dc_ready) rdy_seen++;
        end
        check("t4_no_we",    we_seen,  0);
        check("t4_no_ready", rdy_seen, 0);

        // Address change and request drop after grant
        bus0.ic_req  = 1'b1;
        bus0.ic_addr = 26'h10;
        for (int c = 1; c <= 6; c++) begin
            step();
            if (c == 2) begin
                bus0.ic_addr = 26'h20;
                bus0.ic_req  = 1'b0;
            end
            if (c <= 5) check("t5_rd_addr", bus0.mem_rd_addr, 26'h10);
            else begin
                check("t5_ready",    bus0.ic_ready, 1'b1);
                check("t5_ic_rdata", bus0.ic_rdata, LINE_10);
            end
        end
        step();
        check("t5_idle_busy", busy0, 1'b0);

        // Latency 1, request held continuously
        bus1.ic_req  = 1'b1;
        bus1.ic_addr = 26'h30;
        for (int c = 1; c <= 12; c++) begin
            step();
            check($sformatf("t6_ready_c%0d", c), bus1.ic_ready, (c % 3) == 2);
        end
        bus1.ic_req = 1'b0;
        check("t6_ic_rdata", bus1.ic_rdata, LINE_30);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule

// File: doc/mem_line_requester.md
Name: mem_line_requester

Overview:
- Initiator side of the 128-bit line memory interface.
- Accepts line-fill requests from the I-cache and line read/write requests from the D-cache, and arbitrates between them.
- Drives the memory's read address, write address, write data and write-enable, and holds each access for a fixed latency.
- Registers the returned line and hands it back with a one-cycle ready pulse.

Parameters:
- ADDR_W, 26, line address width (memory word index = addr<<2).
- LINE_W, 128, line data width.
- MEM_LATENCY, 5, cycles an access is held on the memory port; legal range 1..15.

Ports:
- clk  in  1  rising-edge clock
- reset  in  1  synchronous, active-high
- ic_req  in  1  I-cache line-fill request (level, held until ic_ready)
- ic_addr  in  ADDR_W  I-cache line address
- ic_ready  out  1  one-cycle pulse: ic_rdata valid
- ic_rdata  out  LINE_W  returned line for I-cache
- dc_req  in  1  D-cache request (level, held until dc_ready)
- dc_we  in  1  1 = line write, 0 = line read
- dc_addr  in  ADDR_W  D-cache line address
- dc_wdata  in  LINE_W  D-cache write line
- dc_ready  out  1  one-cycle pulse: read data valid / write committed
- dc_rdata  out  LINE_W  returned line for D-cache
- mem_rd_addr  out  ADDR_W  memory read line address
- mem_wr_addr  out  ADDR_W  memory write line address
- mem_wdata  out  LINE_W  memory write line
- mem_we  out  1  memory write strobe
- mem_rdata  in  LINE_W  memory read line (combinational from mem_rd_addr)
- busy  out  1  high in any state other than IDLE

Behaviour:
- Reset (synchronous, active-high): every output is 0, state is IDLE, the counter is 0, and the grant-history bit is 0.
- State machine:
  - IDLE: if any request is pending, grant one requester, latch its addr/we/wdata and the requester id, load cnt = MEM_LATENCY-1, and go to ACCESS.
  - ACCESS: mem_rd_addr and mem_wr_addr both drive the latched address; mem_wdata drives the latched wdata; cnt decrements each cycle.
  - When cnt==0 in ACCESS: sample mem_rdata into the granted requester's rdata register; if the access is a write, assert mem_we for this cycle only; go to DONE.
  - DONE: assert the granted requester's ready for exactly one cycle, then return to IDLE unconditionally.
- Latency: a request seen in IDLE at edge t produces ready high in cycle t+MEM_LATENCY+1. Back-to-back accesses are spaced at minimum MEM_LATENCY+2 cycles, because DONE is never followed directly by a grant.
- mem_we is high for exactly one cycle per write and never during reads, IDLE or DONE. No write is ever issued from a read request.
- Address, data and output registers:
  - mem_rd_addr, mem_wr_addr and mem_wdata return to 0 in IDLE.
  - The latched address and data are immune to changes on request inputs after grant.
  - ic_rdata and dc_rdata hold their last value until the next completed read for that requester; a dc write does not change dc_rdata.
- Arbitration (default): fixed priority, dc over ic. When both requests are high in IDLE, dc is granted.
- Boundary conditions:
  - A requester that drops req mid-access: the transaction still completes, and the ready pulse is still issued.
  - req still high in DONE: treated as a new request in the following IDLE cycle.
  - Reset during ACCESS/DONE: the access is aborted, no mem_we pulse, no ready pulse, and all outputs are 0 next cycle.
  - MEM_LATENCY=1: ACCESS lasts exactly one cycle.
  - Address wraps modulo 2^ADDR_W; no range check.

Optional Feature:
- Macro MEMREQ_ROUND_ROBIN_EN.
- When defined: the grant-history bit records the last granted requester. When both requests are pending in IDLE, the requester not granted last wins. A single pending request always wins regardless of history.
- When undefined: fixed dc-over-ic priority, and the history bit is absent.

Test Plan:
- ic_req=1, ic_addr=0x0000010 after reset, mem_rdata model returns {w67,w66,w65,w64}:
  - mem_rd_addr=0x10 for 5 cycles;
  - ic_ready pulses in cycle 6 after the request;
  - ic_rdata equals that line;
  - mem_we stays 0 throughout.
- dc_req=1, dc_we=1, dc_addr=0x0000400, dc_wdata=128'hDEADBEEF_01234567_89ABCDEF_CAFEF00D:
  - mem_we is high for exactly one cycle (the 5th ACCESS cycle) with mem_wr_addr=0x400 and the given data;
  - dc_ready pulses the next cycle;
  - dc_rdata is unchanged.
- ic_req and dc_req raised together and held:
  - default build: dc served, then ic, with grants 7 cycles apart;
  - with MEMREQ_ROUND_ROBIN_EN and history=dc: ic is served first.
- dc write in progress, reset asserted at ACCESS cycle 3:
  - no mem_we pulse, no dc_ready;
  - all outputs 0 the next cycle;
  - busy=0.
- ic_addr changed from 0x10 to 0x20 two cycles after grant: mem_rd_addr stays 0x10 until DONE; the returned line is from 0x10.
- Build with MEM_LATENCY=1, ic_req held continuously: ic_ready pulses every 3 cycles.
